// File: rtl/dma_sequencer.sv
// Descriptor queue plus chunking FSM in front of dma_controller: pops descriptors in
// FIFO order, splits them into bursts of at most MAX_BURST words, counts completions.
module dma_sequencer #(
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic                     desc_dir,
  input  logic [31:0]              desc_src,
  input  logic [31:0]              desc_dst,
  input  logic [31:0]              desc_len,
  output logic                     dma_start,
  output logic                     dma_dir,
  output logic [31:0]              dma_src_addr,
  output logic [31:0]              dma_dst_addr,
  output logic [31:0]              dma_len,
  input  logic                     dma_done,
  input  logic                     dma_idle,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [31:0]              done_count,
  output logic                     desc_err,
  input  logic                     done_clear
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW:0]       DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [31:0]       BURST_C = 32'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  typedef struct packed {
    logic        dir;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } desc_t;

  state_t        r_state, w_state_nxt;
  desc_t         r_q_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_cur_dir;
  logic [31:0]   r_cur_src, r_cur_dst, r_rem;
  logic [31:0]   r_done_count;
  logic          r_desc_err;

  desc_t         w_head;
  logic          w_push, w_pop, w_zero_pop, w_advance, w_complete, w_dma_start;
  logic [31:0]   w_chunk, w_chunk_bytes, w_src_step, w_dst_step;

  assign w_head     = r_q_mem[r_rd_ptr];
  assign desc_ready = (r_count < DEPTH_C);
  assign w_push     = desc_valid & desc_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_zero_pop = w_pop && (w_head.len == 32'd0);

  assign w_chunk       = (r_rem > BURST_C) ? BURST_C : r_rem;
  assign w_chunk_bytes = w_chunk << 2;
  // DDR side is byte addressed, DMem side word addressed; dir picks which is which.
  assign w_src_step    = r_cur_dir ? w_chunk : w_chunk_bytes;
  assign w_dst_step    = r_cur_dir ? w_chunk_bytes : w_chunk;
  assign w_advance     = (r_state == S_WAIT) && dma_done;
  assign w_complete    = w_advance && (r_rem == w_chunk);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_dma_start = 1'b0;
    case (r_state)
      S_IDLE:  if (w_pop && !w_zero_pop) w_state_nxt = S_START;
      S_START: begin
        w_dma_start = 1'b1;
        if (dma_idle) w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (dma_done) w_state_nxt = (r_rem == w_chunk) ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the queue storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_q_mem[r_wr_ptr] <= '{dir: desc_dir, src: desc_src, dst: desc_dst, len: desc_len};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur_dir <= 1'b0;
      r_cur_src <= '0;
      r_cur_dst <= '0;
      r_rem     <= '0;
    end else if (w_pop) begin
      r_cur_dir <= w_head.dir;
      r_cur_src <= w_head.src;
      r_cur_dst <= w_head.dst;
      r_rem     <= w_head.len;
    end else if (w_advance) begin
      r_rem     <= r_rem - w_chunk;
      r_cur_src <= r_cur_src + w_src_step;
      r_cur_dst <= r_cur_dst + w_dst_step;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done_count <= '0;
      r_desc_err   <= 1'b0;
    end else begin
      if (w_complete)      r_done_count <= done_clear ? 32'd1 : r_done_count + 32'd1;
      else if (done_clear) r_done_count <= '0;
      if (w_zero_pop)      r_desc_err <= 1'b1;
      else if (done_clear) r_desc_err <= 1'b0;
    end
  end

  assign dma_start    = w_dma_start;
  assign dma_dir      = r_cur_dir;
  assign dma_src_addr = r_cur_src;
  assign dma_dst_addr = r_cur_dst;
  assign dma_len      = w_chunk;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);
  assign queue_count  = r_count;
  assign done_count   = r_done_count;
  assign desc_err     = r_desc_err;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: a chunk-vector table driven through a simple
// controller model, then queue-full, zero-length/clear and reset sequences.
module tb_dma_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        desc_valid = 1'b0, desc_dir = 1'b0;
  logic [31:0] desc_src = '0, desc_dst = '0, desc_len = '0;
  logic        dma_done = 1'b0, dma_idle = 1'b1, done_clear = 1'b0;
  logic        desc_ready, dma_start, dma_dir, busy, desc_err;
  logic [31:0] dma_src_addr, dma_dst_addr, dma_len, done_count;
  logic [2:0]  queue_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  dma_sequencer #(.DEPTH(4), .MAX_BURST(256)) dut (
    .clk(clk), .resetn(resetn),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dir(desc_dir),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_src_addr(dma_src_addr),
    .dma_dst_addr(dma_dst_addr), .dma_len(dma_len),
    .dma_done(dma_done), .dma_idle(dma_idle),
    .busy(busy), .queue_count(queue_count), .done_count(done_count),
    .desc_err(desc_err), .done_clear(done_clear)
  );

  initial forever #5 clk = ~clk;

  // Starts the controller actually accepts (start high while it is idle).
  always @(posedge clk) if (resetn && dma_start && dma_idle) n_starts <= n_starts + 1;

  typedef struct {
    logic        push;
    logic        dir;
    logic [31:0] src, dst, len;
    logic        e_dir;
    logic [31:0] e_src, e_dst, e_len;
    int          e_lat;
    logic [31:0] e_done;
    logic        e_busy;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic dir, input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] l);
    @(negedge clk);
    desc_dir = dir; desc_src = s; desc_dst = d; desc_len = l; desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (dma_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_chunk(input int gap);
    dma_done = 1'b0;
    repeat (gap) @(negedge clk);
    dma_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    done_clear = 1'b1;
    @(negedge clk);
    done_clear = 1'b0;
    check("clear_done_count", done_count, 32'd0);
    check("clear_desc_err", 32'(desc_err), 32'd0);
  endtask

  initial begin
    int lat;
    int base;

    //          push  dir   src            dst            len           e_dir e_src          e_dst          e_len      lat done  busy
    vec[0] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0000_0100, 32'd10,  1'b0, 32'h1000_0000, 32'h0000_0100, 32'd10,  1, 32'd1, 1'b0};
    vec[1] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0000_0100, 32'd600, 1'b0, 32'h1000_0000, 32'h0000_0100, 32'd256, 1, 32'd1, 1'b1};
    vec[2] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'd0,   1'b0, 32'h1000_0400, 32'h0000_0200, 32'd256, 0, 32'd1, 1'b1};
    vec[3] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'd0,   1'b0, 32'h1000_0800, 32'h0000_0300, 32'd88,  0, 32'd2, 1'b0};
    vec[4] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1000_0000, 32'd600, 1'b1, 32'h0000_0100, 32'h1000_0000, 32'd256, 1, 32'd2, 1'b1};
    vec[5] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'd0,   1'b1, 32'h0000_0200, 32'h1000_0400, 32'd256, 0, 32'd2, 1'b1};
    vec[6] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'd0,   1'b1, 32'h0000_0300, 32'h1000_0800, 32'd88,  0, 32'd3, 1'b0};
    vec[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd257, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd256, 1, 32'd3, 1'b1};
    vec[8] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'd0,   1'b0, 32'h0000_03FC, 32'h0000_00FF, 32'd1,   0, 32'd4, 1'b0};
    vec[9] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_2000, 32'd256, 1'b1, 32'h0000_0040, 32'h0000_2000, 32'd256, 1, 32'd5, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_desc_ready", 32'(desc_ready), 32'd1);
    check("rst_dma_start", 32'(dma_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_queue_count", 32'(queue_count), 32'd0);
    check("rst_done_count", done_count, 32'd0);
    check("rst_desc_err", 32'(desc_err), 32'd0);
    check("rst_dma_len", dma_len, 32'd0);
    check("rst_dma_src", dma_src_addr, 32'd0);
    resetn = 1'b1;

    // Chunk vector table: each row is one expected start and its completion.
    base = n_starts;
    for (int i = 0; i < 10; i++) begin
      if (vec[i].push) push(vec[i].dir, vec[i].src, vec[i].dst, vec[i].len);
      wait_start(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vec[i].e_lat));
      check($sformatf("v%0d_src", i), dma_src_addr, vec[i].e_src);
      check($sformatf("v%0d_dst", i), dma_dst_addr, vec[i].e_dst);
      check($sformatf("v%0d_len", i), dma_len, vec[i].e_len);
      check($sformatf("v%0d_dir", i), 32'(dma_dir), 32'(vec[i].e_dir));
      dma_done = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_start_one_cycle", i), 32'(dma_start), 32'd0);
      check($sformatf("v%0d_len_stable", i), dma_len, vec[i].e_len);
      finish_chunk(18);
      check($sformatf("v%0d_done_count", i), done_count, vec[i].e_done);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].e_busy));
    end
    dma_done = 1'b0;
    check("table_start_total", 32'(n_starts - base), 32'd10);

    // Queue full: controller stuck busy, five pushes back to back, then a refused sixth.
    pulse_clear();
    base = n_starts;
    dma_idle = 1'b0;
    for (int i = 0; i < 5; i++) begin
      desc_dir = 1'(i); desc_src = 32'h5000 + 32'(i * 16); desc_dst = 32'(i);
      desc_len = 32'(i + 1); desc_valid = 1'b1;
      @(negedge clk);
    end
    check("full_desc_ready", 32'(desc_ready), 32'd0);
    check("full_queue_count", 32'(queue_count), 32'd4);
    desc_src = 32'h9999; desc_len = 32'd9;
    @(negedge clk);
    desc_valid = 1'b0;
    check("full_refused_push", 32'(queue_count), 32'd4);
    check("full_head_start", 32'(dma_start), 32'd1);
    check("full_head_src", dma_src_addr, 32'h5000);
    dma_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_start(lat);
      check($sformatf("drain%0d_src", i), dma_src_addr, 32'h5000 + 32'(i * 16));
      check($sformatf("drain%0d_len", i), dma_len, 32'(i + 1));
      check($sformatf("drain%0d_dir", i), 32'(dma_dir), 32'(i % 2));
      dma_done = 1'b0;
      @(negedge clk);
      finish_chunk(0);
    end
    dma_done = 1'b0;
    check("drain_done_count", done_count, 32'd5);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_start_total", 32'(n_starts - base), 32'd5);

    // Zero-length descriptor followed by a one-word descriptor.
    pulse_clear();
    base = n_starts;
    push(1'b0, 32'hAAA0, 32'h0, 32'd0);
    push(1'b0, 32'h2000, 32'h30, 32'd1);
    check("zero_desc_err", 32'(desc_err), 32'd1);
    wait_start(lat);
    check("zero_next_len", dma_len, 32'd1);
    check("zero_next_src", dma_src_addr, 32'h2000);
    dma_done = 1'b0;
    @(negedge clk);
    finish_chunk(3);
    dma_done = 1'b0;
    check("zero_done_count", done_count, 32'd1);
    check("zero_err_sticky", 32'(desc_err), 32'd1);

    // Clear in the same cycle as a zero-length pop: the error stays set.
    push(1'b0, 32'hBBB0, 32'h0, 32'd0);
    done_clear = 1'b1;
    @(negedge clk);
    done_clear = 1'b0;
    check("clrpop_desc_err", 32'(desc_err), 32'd1);
    check("clrpop_done_count", done_count, 32'd0);

    // Clear in the same cycle as a completion: count lands on 1, not 0 or 2.
    push(1'b0, 32'h3000, 32'h40, 32'd1);
    wait_start(lat);
    dma_done = 1'b0;
    @(negedge clk);
    finish_chunk(2);
    dma_done = 1'b0;
    check("clrcmp_pre_count", done_count, 32'd1);
    push(1'b0, 32'h3100, 32'h50, 32'd1);
    wait_start(lat);
    dma_done = 1'b0;
    @(negedge clk);
    dma_done = 1'b1;
    done_clear = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    done_clear = 1'b0;
    check("clrcmp_done_count", done_count, 32'd1);
    check("clrcmp_desc_err", 32'(desc_err), 32'd0);
    check("zero_start_total", 32'(n_starts - base), 32'd3);

    // Reset while waiting on a chunk with two descriptors still queued.
    base = n_starts;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      desc_dir = 1'b0; desc_src = 32'h7000 + 32'(i * 16); desc_dst = 32'h70;
      desc_len = 32'd5; desc_valid = 1'b1;
      @(negedge clk);
    end
    desc_valid = 1'b0;
    check("mid_queue_count", 32'(queue_count), 32'd2);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_in_wait", 32'(dma_start), 32'd0);
    check("mid_len", dma_len, 32'd5);
    #2 resetn = 1'b0;
    #1;
    check("arst_queue_count", 32'(queue_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_desc_ready", 32'(desc_ready), 32'd1);
    check("arst_dma_len", dma_len, 32'd0);
    check("arst_dma_src", dma_src_addr, 32'd0);
    check("arst_dma_dst", dma_dst_addr, 32'd0);
    check("arst_done_count", done_count, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_start", 32'(n_starts - base), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Reset while start is held: the start must drop without waiting for a clock.
    dma_idle = 1'b0;
    push(1'b1, 32'h80, 32'h8000, 32'd4);
    wait_start(lat);
    check("hold_start_seen", 32'(dma_start), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_start_drop", 32'(dma_start), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    dma_idle = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst2_start", 32'(dma_start), 32'd0);
    check("post_rst2_queue", 32'(queue_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
